// File: rtl/vga_timing_out.sv
// vga_timing_out: 640x480 raster counters, sync/blank delay line,
// and registered 3:3:2 -> 4:4:4 colour output stage.
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE     = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC - 1;

    logic [10:0] hCnt;
    logic [10:0] vCnt;
    logic        hWrap;
    logic        vWrap;
    logic        visNow;
    logic        hsNow;
    logic        vsNow;
    // {visible, hs, vs} per stage; stage PIPE-1 lines up with RGBIn
    logic [2:0]  flagD [PIPE];
    logic [2:0]  flagOut;

    assign hWrap = (hCnt == 11'(H_TOTAL - 1));
    assign vWrap = (vCnt == 11'(V_TOTAL - 1));

    assign visNow = (hCnt < 11'(H_ACTIVE)) && (vCnt < 11'(V_ACTIVE));
    assign hsNow  = (hCnt >= 11'(HS_BEG)) && (hCnt <= 11'(HS_END));
    assign vsNow  = (vCnt >= 11'(VS_BEG)) && (vCnt <= 11'(VS_END));

    // The counters are the coordinate registers themselves.
    assign pixelX = hCnt;
    assign pixelY = vCnt;

    // Gated by resetN so the pulse is low in reset yet high on the
    // very first cycle after release, when the raster sits at (0,0).
    assign startOfFrame = resetN && (hCnt == '0) && (vCnt == '0);

    assign flagOut = flagD[PIPE-1];

    // Raster counters: vertical steps only on the horizontal wrap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hWrap) begin
            hCnt <= '0;
            vCnt <= vWrap ? '0 : vCnt + 11'd1;
        end else begin
            hCnt <= hCnt + 11'd1;
        end
    end

    // Delay the flags so they meet the pixel coming back from the mux.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE; i++) begin
                flagD[i] <= '0;
            end
        end else begin
            flagD[0] <= {visNow, hsNow, vsNow};
            for (int i = 1; i < PIPE; i++) begin
                flagD[i] <= flagD[i-1];
            end
        end
    end

    // Pin register: colour expansion, blank forcing, active-low syncs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            blankN <= 1'b0;
        end else begin
            hSync  <= ~flagOut[1];
            vSync  <= ~flagOut[0];
            blankN <= flagOut[2];
            if (flagOut[2]) begin
                red   <= {RGBIn[7:5], RGBIn[7]};
                green <= {RGBIn[4:2], RGBIn[4]};
                blue  <= {RGBIn[1:0], RGBIn[1:0]};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: random pixel stream against a raster model
// computed from cycle index; shortened frame keeps runs brief.
module tb_vga_timing_out;

    localparam int HA    = 640;
    localparam int HF    = 16;
    localparam int HS    = 96;
    localparam int HB    = 48;
    localparam int VA    = 12;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int PIPE  = 2;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT   = PIPE + 1;
    // mid-frame reset point: x=700 on the first vsync line
    localparam int RST_POS = (VA + VF) * HT + 700;

    logic        clk;
    logic        resetN;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hSync;
    logic        vSync;
    logic        blankN;

    int checks;
    int errors;

    logic [7:0] hist[$];
    int hLow, vLow, hRuns, vRuns, sofCnt, lastSof, stopM;

    vga_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE(PIPE)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .RGBIn(RGBIn),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .startOfFrame(startOfFrame),
        .red(red),
        .green(green),
        .blue(blue),
        .hSync(hSync),
        .vSync(vSync),
        .blankN(blankN)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit vis_at(int c);
        return ((c % HT) < HA) && (((c / HT) % VT) < VA);
    endfunction

    function automatic bit hs_at(int c);
        int h = c % HT;
        return (h >= HA + HF) && (h < HA + HF + HS);
    endfunction

    function automatic bit vs_at(int c);
        int v = (c / HT) % VT;
        return (v >= VA + VF) && (v < VA + VF + VS);
    endfunction

    // 3-bit field to 4 bits: double it and append its MSB
    function automatic int exp3(int f);
        return f * 2 + f / 4;
    endfunction

    function automatic int exp_rgb(int p);
        return (exp3(p / 32) << 8) | (exp3((p / 4) % 8) << 4)
             | ((p % 4) * 5);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 32'(pixelX), 0);
        chk({tag, "_y"}, 32'(pixelY), 0);
        chk({tag, "_sof"}, 32'(startOfFrame), 0);
        chk({tag, "_rgb"}, 32'({red, green, blue}), 0);
        chk({tag, "_hs"}, 32'(hSync), 1);
        chk({tag, "_vs"}, 32'(vSync), 1);
        chk({tag, "_bl"}, 32'(blankN), 0);
    endtask

    // Runs from release; cycle m is the span after edge m.
    task automatic run(input int ncyc, input bit stopEarly);
        int sel;
        int c;
        int expCol;
        hist.delete();
        hLow = 0;
        vLow = 0;
        lastSof = -1;
        stopM = -1;
        for (int m = 0; m < ncyc; m++) begin
            if (m < HT) begin
                RGBIn = 8'hFF;
            end else begin
                sel = $urandom_range(0, 3);
                if (sel == 0)      RGBIn = 8'b101_011_10;
                else if (sel == 1) RGBIn = 8'h00;
                else               RGBIn = 8'($urandom);
            end
            hist.push_back(RGBIn);
            @(negedge clk);
            chk("pixelX", 32'(pixelX), m % HT);
            chk("pixelY", 32'(pixelY), (m / HT) % VT);
            chk("sof", 32'(startOfFrame), int'((m % FRAME) == 0));
            c = m - LAT;
            if (c < 0) begin
                chk("bl_pre", 32'(blankN), 0);
                chk("hs_pre", 32'(hSync), 1);
                chk("vs_pre", 32'(vSync), 1);
                chk("rgb_pre", 32'({red, green, blue}), 0);
            end else begin
                expCol = vis_at(c) ? exp_rgb(int'(hist[m-1])) : 0;
                chk("blankN", 32'(blankN), int'(vis_at(c)));
                chk("hSync", 32'(hSync), int'(!hs_at(c)));
                chk("vSync", 32'(vSync), int'(!vs_at(c)));
                chk("rgb", 32'({red, green, blue}), expCol);
            end
            if (!hSync) begin
                hLow++;
            end else if (hLow != 0) begin
                chk("hs_len", hLow, HS);
                hRuns++;
                hLow = 0;
            end
            if (!vSync) begin
                vLow++;
            end else if (vLow != 0) begin
                chk("vs_len", vLow, VS * HT);
                vRuns++;
                vLow = 0;
            end
            if (startOfFrame) begin
                if (lastSof >= 0) chk("sof_per", m - lastSof, FRAME);
                lastSof = m;
                sofCnt++;
            end
            if (stopEarly && m >= 2 * FRAME && (m % FRAME) == RST_POS) begin
                stopM = m;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hRuns = 0;
        vRuns = 0;
        sofCnt = 0;
        resetN = 1'b0;
        RGBIn = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk);
        #1;
        resetN = 1'b1;

        run(3 * FRAME, 1'b1);
        chk("stop_hit", int'(stopM >= 0), 1);
        chk("sof_cnt", sofCnt, 3);
        chk("vs_runs", vRuns, 2);
        chk("hs_runs", hRuns, stopM / HT);
        // both syncs are active here; reset must clear them at once
        chk("pre_rst_hs", 32'(hSync), 0);
        chk("pre_rst_vs", 32'(vSync), 0);

        #5;
        resetN = 1'b0;
        #1;
        chk_reset("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("hold");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        sofCnt = 0;
        run(2 * HT, 1'b0);
        chk("sof_cnt2", sofCnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
